mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have no parameters; all encodings are fixed constants.
REQ-002 SHALL expose ports exactly:
  clk  in  1  single clock; all state updates on rising edge
  reset  in  1  asynchronous, active-low reset
  op  in  7  instr[6:0], from the instruction register
  funct3  in  3  instr[14:12]
  funct7b5  in  1  instr[30]
  Zero  in  1  ALU zero flag
  PCWrite  out  1  PC register enable
  AdrSrc  out  1  memory address select (0=PC, 1=Result)
  MemWrite  out  1  data memory write enable
  IRWrite  out  1  instruction register enable
  RegWrite  out  1  register-file write enable (drives WE3)
  ResultSrc  out  2  result mux select
  ALUSrcA  out  2  ALU A select
  ALUSrcB  out  2  ALU B select
  ALUControl  out  3  ALU operation
  ImmSrc  out  2  immediate format
  illegal_op  out  1  unrecognised opcode seen in DECODE
  instret  out  32  retired-instruction count
  state  out  4  current FSM state (debug)

Function
REQ-003 SHALL be a Moore FSM; state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 go to FETCH on the next edge.
REQ-004 SHALL transition FETCH->DECODE unconditionally.
REQ-005 DECODE SHALL go to:
  MEMADR for op 0000011 or 0100011
  EXECUTER for 0110011
  EXECUTEI for 0010011
  JAL for 1101111
  BEQ for 1100011
  FETCH otherwise
REQ-006 MEMADR SHALL go to MEMREAD if op=0000011, else MEMWRITE.
REQ-007 SHALL transition:
  MEMREAD->MEMWB
  MEMWB->FETCH
  MEMWRITE->FETCH
  EXECUTER/EXECUTEI->ALUWB
  JAL->ALUWB
  ALUWB->FETCH
  BEQ->FETCH
REQ-008 Per-state outputs SHALL be as listed; unlisted outputs are 0.
  FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
  DECODE: ALUSrcA=01, ALUSrcB=01.
  MEMADR: ALUSrcA=10, ALUSrcB=01.
  MEMREAD: AdrSrc=1.
  MEMWB: ResultSrc=01, RegWrite=1.
  MEMWRITE: AdrSrc=1, MemWrite=1.
  EXECUTER: ALUSrcA=10, ALUOp=10.
  EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  ALUWB: RegWrite=1.
  BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
  JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-009 PCWrite SHALL equal PCUpdate OR (Branch AND Zero).
REQ-010 ALUControl SHALL be decoded from ALUOp, funct3, funct7b5 and op[5]:
  ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub).
  ALUOp 10, funct3 000 -> 001 if funct7b5 AND op[5], else 000.
  ALUOp 10, funct3 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
REQ-011 ImmSrc SHALL be combinational from op: 0100011->01, 1100011->10, 1101111->11, otherwise 00.
REQ-012 illegal_op SHALL be 1 only while in DECODE with an op not listed in REQ-005; it is combinational and lasts one cycle.
REQ-013 instret SHALL increment by 1, wrapping mod 2^32, on each clock edge on which state leaves MEMWB, MEMWRITE, ALUWB or BEQ.
REQ-014 An illegal op SHALL NOT increment instret.
REQ-015 Instruction latencies SHALL be, in cycles including FETCH: lw 5, sw 4, R/I-type 4, jal 4, beq 3.

Reset
REQ-016 While reset=0, state SHALL be FETCH and instret SHALL be 0, taking effect asynchronously.
REQ-017 While reset=0, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced 0; the other outputs follow FETCH decode.
REQ-018 Reset asserted mid-instruction SHALL abandon that instruction without counting it.
REQ-019 The first rising edge after reset deasserts SHALL perform the FETCH actions.

Structure
REQ-020 State encodings, opcode constants, ALUOp codes and ALUControl codes SHALL live in a shared definitions package, rv_ctrl_pkg, reused by the datapath.
REQ-021 The ALU decoding of REQ-010 SHALL be a sub-module, alu_decoder, that is purely combinational.
REQ-022 The top level SHALL hold the state register, next-state logic, output decode and the instret counter.

Verification
REQ-023 reset=0 for 2 cycles -> state=0, PCWrite=IRWrite=RegWrite=MemWrite=0, instret=0.
REQ-024 op=0000011 after reset -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; instret=1.
REQ-025 op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in state 6; RegWrite=1 in state 8; instret increments after 4 cycles.
REQ-026 op=1100011 with Zero=1 in BEQ -> PCWrite=1. With Zero=0 -> PCWrite=0. In both cases: states 0,1,9,0.
REQ-027 op=1111111 -> illegal_op=1 in DECODE, next state FETCH, instret unchanged.
REQ-028 reset=0 asserted in state 3 -> state=0 immediately, instret=0, no RegWrite pulse.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_ctrl_pkg : shared state, opcode and ALU encodings for the core      |
// | Revision    : 1.0                                                      |
// +----------------------------------------------------------------------+
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_BEQ   = 7'b1100011;

  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_SLT = 3'b101;

  function automatic logic is_known_op(input logic [6:0] op);
    return op inside {c_OP_LOAD, c_OP_STORE, c_OP_RTYPE, c_OP_ITYPE, c_OP_JAL, c_OP_BEQ};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_decoder : maps ALUOp/funct fields to an ALU operation (comb only)  |
// | Revision    : 1.0                                                      |
// +----------------------------------------------------------------------+
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op_b5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = c_ALU_ADD;
    case (i_alu_op)
      c_ALUOP_SUB: o_alu_control = c_ALU_SUB;
      c_ALUOP_FUNCT: begin
        case (i_funct3)
          // sub only for R-type; an I-type addi shares funct7b5 with its immediate
          3'b000:  o_alu_control = (i_funct7b5 & i_op_b5) ? c_ALU_SUB : c_ALU_ADD;
          3'b010:  o_alu_control = c_ALU_SLT;
          3'b110:  o_alu_control = c_ALU_OR;
          3'b111:  o_alu_control = c_ALU_AND;
          default: o_alu_control = c_ALU_ADD;
        endcase
      end
      default: o_alu_control = c_ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_control : multicycle RISC-V controller FSM with retired-instr count |
// | Revision   : 1.0                                                       |
// +----------------------------------------------------------------------+
module mc_control
  import rv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        illegal_op,
  output logic [31:0] instret,
  output logic [3:0]  state
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_instret;
  logic        w_pc_update;
  logic        w_branch;
  logic        w_irwrite;
  logic        w_regwrite;
  logic        w_memwrite;
  logic        w_retire;
  logic [1:0]  w_alu_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          c_OP_LOAD, c_OP_STORE: w_next_state = S_MEMADR;
          c_OP_RTYPE:            w_next_state = S_EXECUTER;
          c_OP_ITYPE:            w_next_state = S_EXECUTEI;
          c_OP_JAL:              w_next_state = S_JAL;
          c_OP_BEQ:              w_next_state = S_BEQ;
          default:               w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:                      w_next_state = (op == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:                     w_next_state = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: w_next_state = S_ALUWB;
      default:                       w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_memwrite  = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    w_alu_op    = c_ALUOP_ADD;
    case (r_state)
      S_FETCH:    begin w_irwrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; w_pc_update = 1'b1; end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; w_regwrite = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; w_memwrite = 1'b1; end
      S_EXECUTER: begin ALUSrcA = 2'b10; w_alu_op = c_ALUOP_FUNCT; end
      S_EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; w_alu_op = c_ALUOP_FUNCT; end
      S_ALUWB:    w_regwrite = 1'b1;
      S_BEQ:      begin ALUSrcA = 2'b10; w_alu_op = c_ALUOP_SUB; w_branch = 1'b1; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; w_pc_update = 1'b1; end
      default:    ;
    endcase
  end

  always_comb begin
    case (op)
      c_OP_STORE: ImmSrc = 2'b01;
      c_OP_BEQ:   ImmSrc = 2'b10;
      c_OP_JAL:   ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op_b5       (op[5]),
    .o_alu_control (ALUControl)
  );

  // Enables are gated by reset so nothing architectural changes while held in reset.
  assign PCWrite  = reset & (w_pc_update | (w_branch & Zero));
  assign IRWrite  = reset & w_irwrite;
  assign RegWrite = reset & w_regwrite;
  assign MemWrite = reset & w_memwrite;

  assign illegal_op = (r_state == S_DECODE) && !is_known_op(op);

  assign w_retire = r_state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_instret <= 32'd0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_control : directed table, reset sequences and random instrs      |
// | Revision      : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_mc_control;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  op = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7b5 = 1'b0;
  logic        Zero = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;
  logic [3:0]  state;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal_op(illegal_op),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned model_instret = 0;
  int          exp_seq[$];

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         len;
    logic [2:0] ac3;
    logic [1:0] imm;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic known(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
  endfunction

  // Expected state walk for one instruction, straight from the opcode's class.
  task automatic build_seq(input logic [6:0] o);
    exp_seq.delete();
    case (o)
      7'b0000011: exp_seq = '{0, 1, 2, 3, 4};
      7'b0100011: exp_seq = '{0, 1, 2, 5};
      7'b0110011: exp_seq = '{0, 1, 6, 8};
      7'b0010011: exp_seq = '{0, 1, 7, 8};
      7'b1101111: exp_seq = '{0, 1, 10, 8};
      7'b1100011: exp_seq = '{0, 1, 9};
      default:    exp_seq = '{0, 1};
    endcase
  endtask

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,illegal_op}
  function automatic logic [16:0] exp_outs(input int st, input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7, input logic z, input logic rst_n);
    logic pcu, br, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, aop, imm;
    logic [2:0] ac;
    pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 0; sa = 0; sb = 0; aop = 0;
    case (st)
      0:  begin irw = 1; sb = 2; rs = 2; pcu = 1; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; aop = 2; end
      7:  begin sa = 2; sb = 1; aop = 2; end
      8:  rw = 1;
      9:  begin sa = 2; aop = 1; br = 1; end
      10: begin sa = 1; sb = 2; pcu = 1; end
      default: ;
    endcase
    if (aop == 1) ac = 3'b001;
    else if (aop == 2) begin
      if (f3 == 3'b000)      ac = (f7 && o[5]) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) ac = 3'b101;
      else if (f3 == 3'b110) ac = 3'b011;
      else if (f3 == 3'b111) ac = 3'b010;
      else                   ac = 3'b000;
    end else ac = 3'b000;
    imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 : (o == 7'b1101111) ? 2'b11 : 2'b00;
    ill = (st == 1) && !known(o);
    return {rst_n & (pcu | (br & z)), adr, rst_n & mw, rst_n & irw, rst_n & rw,
            rs, sa, sb, ac, imm, ill};
  endfunction

  function automatic logic [16:0] act_outs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ALUControl, ImmSrc, illegal_op};
  endfunction

  // Called at FETCH, 1 time unit after a rising edge; returns after the walk lands in FETCH again.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                           output int len, output logic [2:0] ac3, output logic [1:0] imm0);
    int cyc;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    #1;
    build_seq(o);
    cyc = 0; ac3 = 3'b000; imm0 = ImmSrc;
    do begin
      if (cyc < exp_seq.size()) begin
        chk($sformatf("state op=%b cyc=%0d", o, cyc), 32'(state), 32'(exp_seq[cyc]));
        chk($sformatf("outs op=%b st=%0d", o, exp_seq[cyc]), 32'(act_outs()),
            32'(exp_outs(exp_seq[cyc], o, f3, f7, z, 1'b1)));
      end
      if (cyc == 2) ac3 = ALUControl;
      @(posedge clk); #1;
      cyc++;
    end while (state != 4'd0 && cyc < 8);
    if (state != 4'd0) chk("walk_timeout", 32'(state), 32'd0);
    len = cyc;
    chk($sformatf("latency op=%b", o), 32'(len), 32'(exp_seq.size()));
    if (known(o)) model_instret++;
    chk($sformatf("instret op=%b", o), instret, model_instret);
  endtask

  vec_t        vecs[13];
  int          len;
  logic [2:0]  ac3;
  logic [1:0]  imm0;
  logic [6:0]  legal_ops[6];

  initial begin
    //            op          f3      f7    z     len ac3     imm
    vecs[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000, 2'b00};
    vecs[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b000, 2'b01};
    vecs[2]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, 2'b00};
    vecs[3]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000, 2'b00};
    vecs[4]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3'b011, 2'b00};
    vecs[5]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 3'b010, 2'b00};
    vecs[6]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 2'b00};
    vecs[7]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 2'b00};
    vecs[8]  = '{7'b0010011, 3'b001, 1'b0, 1'b0, 4, 3'b000, 2'b00};
    vecs[9]  = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 3'b000, 2'b11};
    vecs[10] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, 2'b10};
    vecs[11] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001, 2'b10};
    vecs[12] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 2, 3'b000, 2'b00};
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

    // Reset held for two cycles
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pcwrite", 32'(PCWrite), 32'd0);
    chk("rst_irwrite", 32'(IRWrite), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_fetch_decode", 32'({ResultSrc, ALUSrcB}), 32'b1010);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, len, ac3, imm0);
      chk($sformatf("tbl%0d_len", i), 32'(len), 32'(vecs[i].len));
      chk($sformatf("tbl%0d_alu", i), 32'(ac3), 32'(vecs[i].ac3));
      chk($sformatf("tbl%0d_imm", i), 32'(imm0), 32'(vecs[i].imm));
    end

    // Reset in MEMREAD abandons the load
    op = 7'b0000011; funct3 = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_pre_state", 32'(state), 32'd3);
    reset = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_instret", instret, 32'd0);
    chk("midrst_irwrite", 32'(IRWrite), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_regwrite", 32'(RegWrite), 32'd0);
      chk("midrst_hold_state", 32'(state), 32'd0);
    end
    model_instret = 0;
    reset = 1'b1;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, len, ac3, imm0);

    // Random instruction stream against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [6:0] o;
      if ($urandom_range(0, 7) < 6) o = legal_ops[$urandom_range(0, 5)];
      else                          o = 7'($urandom);
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), len, ac3, imm0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
